pmem_responder: RTL and testbench

Line-granular physical-memory responder: the target end of the `pmem_*` interface driven by the cache arbiter. It accepts one 128-bit line read or write at a time and holds it for a fixed, parameterised latency. It then pulses `pmem_resp` and, for reads, presents the line on `pmem_rdata`. It sits between the arbiter and the line storage, and serves both as the synthesizable memory model for the pipelined core and as the backing store for bring-up.

---
 rtl/pmem_responder_pkg.sv | 19 +
 rtl/pmem_array.sv | 42 ++++
 rtl/pmem_responder.sv | 140 ++++++++++++++
 tb/tb_pmem_responder.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/pmem_responder_pkg.sv
// Shared LC-3b types used by the physical-memory responder.
//   lc3b_word             16-bit byte address
//   lc3b_c_block          128-bit cache line
//   lc3b_pmem_state       responder FSM states
//   LC3B_LINE_OFFSET_BITS byte-offset bits inside a line
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_c_block;

    localparam int unsigned LC3B_LINE_OFFSET_BITS = 4;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } lc3b_pmem_state;

endpackage

// File: rtl/pmem_array.sv
// Single-port line storage for pmem_responder: DEPTH_LINES x 128 bits.
// Synchronous write with write enable, registered read.
//   clk      clock
//   reset_n  synchronous active-low reset (clears only the read register)
//   we       write enable: wdata is stored at idx
//   re       read enable: rdata is loaded from idx
//   idx      line index
//   wdata    line to write
//   rdata    registered read line, held until the next read
module pmem_array
    import lc3b_types::*;
#(
    parameter  int unsigned DEPTH_LINES = 256,
    localparam int unsigned IDX_W       = $clog2(DEPTH_LINES)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             we,
    input  logic             re,
    input  logic [IDX_W-1:0] idx,
    input  lc3b_c_block      wdata,
    output lc3b_c_block      rdata
);

    lc3b_c_block mem [DEPTH_LINES];

    // The storage itself has no reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/pmem_responder.sv
// Line-granular physical-memory responder (target end of the pmem_* bus).
// Accepts one 128-bit line read or write, holds it for LATENCY cycles,
// then pulses pmem_resp for one cycle; reads present the line on pmem_rdata.
//   clk           clock
//   reset_n       synchronous active-low reset
//   pmem_read     line read request (held until pmem_resp)
//   pmem_write    line write request (held until pmem_resp); wins over read
//   pmem_address  byte address, bits [3:0] ignored, upper bits alias
//   pmem_wdata    write line
//   pmem_resp     one-cycle completion pulse (registered: state == RESP)
//   pmem_rdata    registered read line
//   pmem_error    sticky protocol-error flag
// Optional build macro: PMEM_PROTOCOL_CHECK_EN enables the protocol checker;
// without it pmem_error is tied to 0.
module pmem_responder
    import lc3b_types::*;
#(
    parameter int unsigned LATENCY     = 4,
    parameter int unsigned DEPTH_LINES = 256
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        pmem_read,
    input  logic        pmem_write,
    input  lc3b_word    pmem_address,
    input  lc3b_c_block pmem_wdata,
    output logic        pmem_resp,
    output lc3b_c_block pmem_rdata,
    output logic        pmem_error
);

    localparam int unsigned IDX_W = $clog2(DEPTH_LINES);

    lc3b_pmem_state   state;
    lc3b_pmem_state   state_next;
    logic [7:0]       count;
    logic             op_write;
    logic [IDX_W-1:0] line_idx;
    lc3b_c_block      wdata_q;
    logic             req;
    logic             accept;
    logic             done;

    assign req    = pmem_read | pmem_write;
    assign accept = (state == IDLE) && req;
    assign done   = (state == BUSY) && (count == '0);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req) state_next = BUSY;
            BUSY:    if (count == '0) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
        end else if (accept) begin
            count <= 8'(LATENCY - 1);
        end else if ((state == BUSY) && (count != '0)) begin
            count <= count - 8'd1;
        end
    end

    // Request is captured once at acceptance; later input changes are ignored.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_write <= pmem_write;
            line_idx <= pmem_address[LC3B_LINE_OFFSET_BITS +: IDX_W];
            wdata_q  <= pmem_wdata;
        end
    end

    // Commit/read happens on the BUSY->RESP edge, so pmem_rdata is valid in RESP.
    pmem_array #(
        .DEPTH_LINES(DEPTH_LINES)
    ) u_array (
        .clk    (clk),
        .reset_n(reset_n),
        .we     (done && op_write),
        .re     (done && !op_write),
        .idx    (line_idx),
        .wdata  (wdata_q),
        .rdata  (pmem_rdata)
    );

    assign pmem_resp = (state == RESP);

    // Offset bits (and alias bits) are intentionally not decoded.
    logic unused_addr_bits;
    assign unused_addr_bits = ^pmem_address;

`ifdef PMEM_PROTOCOL_CHECK_EN
    lc3b_word addr_q;
    logic     violation;
    logic     error_q;

    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q <= pmem_address;
        end
    end

    always_comb begin
        violation = 1'b0;
        case (state)
            IDLE: if (req) begin
                violation = (pmem_read && pmem_write) ||
                    (32'(pmem_address[15:LC3B_LINE_OFFSET_BITS]) >= DEPTH_LINES);
            end
            BUSY:    violation = !req || (pmem_address != addr_q);
            default: violation = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            error_q <= 1'b0;
        end else if (violation) begin
            error_q <= 1'b1;
        end
    end

    assign pmem_error = error_q;
`else
    assign pmem_error = 1'b0;
`endif

endmodule

// File: tb/tb_pmem_responder.sv
module tb_pmem_responder;

    localparam int unsigned LAT = 4;

`ifdef PMEM_PROTOCOL_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset_n;
    logic         pmem_read, pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic         pmem_resp;
    logic [127:0] pmem_rdata;
    logic         pmem_error;

    logic         rd1, wr1;
    logic [15:0]  addr1;
    logic [127:0] wd1;
    logic         resp1;
    logic [127:0] rdata1;
    logic         err1;

    int unsigned  cyc = 0;
    int unsigned  tests = 0;
    int unsigned  fails = 0;
    int unsigned  resp_count = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pmem_responder #(.LATENCY(LAT), .DEPTH_LINES(256)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata), .pmem_error(pmem_error)
    );

    pmem_responder #(.LATENCY(1), .DEPTH_LINES(256)) u_dut1 (
        .clk(clk), .reset_n(reset_n),
        .pmem_read(rd1), .pmem_write(wr1),
        .pmem_address(addr1), .pmem_wdata(wd1),
        .pmem_resp(resp1), .pmem_rdata(rdata1), .pmem_error(err1)
    );

    typedef struct {
        int unsigned  cyc;
        logic [127:0] data;
        int unsigned  tag;
    } sb_t;

    sb_t sb_q[$];

    typedef struct {
        logic         rd;
        logic         wr;
        logic [15:0]  addr;
        logic [127:0] wd;
        logic [127:0] exp;   // expected pmem_rdata in the RESP cycle
        bit           early; // drop the request two cycles into BUSY
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Scoreboard side: every pmem_resp must match the oldest queued transaction.
    always @(negedge clk) begin
        sb_t e;
        if (pmem_resp) begin
            resp_count++;
            if (sb_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_resp: got resp at cycle %0d, expected none", cyc);
            end else begin
                e = sb_q.pop_front();
                check($sformatf("resp_cycle[%0d]", e.tag), 128'(cyc), 128'(e.cyc));
                check($sformatf("rdata[%0d]", e.tag), pmem_rdata, e.data);
            end
        end
    end

    task automatic run_txn(input logic rd, input logic wr, input logic [15:0] addr,
                           input logic [127:0] wd, input logic [127:0] exp,
                           input bit early, input int unsigned tag);
        bit seen;
        @(negedge clk);
        pmem_read    = rd;
        pmem_write   = wr;
        pmem_address = addr;
        pmem_wdata   = wd;
        sb_q.push_back('{cyc + LAT + 1, exp, tag});
        seen = 1'b0;
        for (int n = 0; n < int'(LAT) + 50 && !seen; n++) begin
            @(negedge clk);
            if (early && n == 1) begin
                pmem_read  = 1'b0;
                pmem_write = 1'b0;
            end
            if (pmem_resp) seen = 1'b1;
        end
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL resp_timeout[%0d]: got no resp, expected resp", tag);
            void'(sb_q.pop_front());
        end
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned resp_before;
        int unsigned c;
        logic [127:0] l11, l22, la5, l33, l44, lff, lc3;
        l11 = {16{8'h11}};
        l22 = {16{8'h22}};
        la5 = {16{8'hA5}};
        l33 = {16{8'h33}};
        l44 = {16{8'h44}};
        lff = {16{8'hFF}};
        lc3 = {16{8'hC3}};

        vecs[0] = '{1'b0, 1'b1, 16'h0040, l11,    128'd0, 1'b0}; // write
        vecs[1] = '{1'b1, 1'b0, 16'h0040, 128'd0, l11,    1'b0}; // read back
        vecs[2] = '{1'b0, 1'b1, 16'h004E, l22,    l11,    1'b0}; // offset ignored, rdata held
        vecs[3] = '{1'b1, 1'b0, 16'h0040, 128'd0, l22,    1'b0};
        vecs[4] = '{1'b1, 1'b1, 16'h0080, la5,    l22,    1'b0}; // both: write wins
        vecs[5] = '{1'b1, 1'b0, 16'h0080, 128'd0, la5,    1'b0};
        vecs[6] = '{1'b0, 1'b1, 16'h0100, l33,    la5,    1'b0};
        vecs[7] = '{1'b0, 1'b1, 16'h1040, l44,    la5,    1'b0}; // aliases onto 0x0040
        vecs[8] = '{1'b1, 1'b0, 16'h0040, 128'd0, l44,    1'b0};
        vecs[9] = '{1'b1, 1'b0, 16'h0080, 128'd0, la5,    1'b1}; // early drop

        reset_n = 1'b0;
        pmem_read = 1'b0; pmem_write = 1'b0; pmem_address = '0; pmem_wdata = '0;
        rd1 = 1'b0; wr1 = 1'b0; addr1 = '0; wd1 = '0;
        repeat (3) @(negedge clk);
        check("reset_resp",  {127'd0, pmem_resp}, 128'd0);
        check("reset_rdata", pmem_rdata, 128'd0);
        check("reset_error", {127'd0, pmem_error}, 128'd0);
        check("reset_resp1", {127'd0, resp1}, 128'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_txn(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd,
                    vecs[i].exp, vecs[i].early, i);
            if (i == 3) check("error_clean", {127'd0, pmem_error}, 128'd0);
            if (i == 4) check("error_both", {127'd0, pmem_error}, {127'd0, EXP_ERR});
        end

        // Reset during BUSY of a write: no commit, no response, outputs cleared.
        @(negedge clk);
        pmem_write = 1'b1; pmem_address = 16'h0100; pmem_wdata = lff;
        resp_before = resp_count;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check("midrst_resp",  {127'd0, pmem_resp}, 128'd0);
        check("midrst_rdata", pmem_rdata, 128'd0);
        check("midrst_error", {127'd0, pmem_error}, 128'd0);
        reset_n = 1'b1;
        pmem_write = 1'b0;
        repeat (LAT + 4) @(negedge clk);
        check("midrst_no_resp", 128'(resp_count), 128'(resp_before));
        run_txn(1'b1, 1'b0, 16'h0100, 128'd0, l33, 1'b0, 20);
        check("error_after_clean", {127'd0, pmem_error}, 128'd0);

        // LATENCY = 1: write then a continuously held read, resp every 3 cycles.
        @(negedge clk);
        wr1 = 1'b1; addr1 = 16'h0040; wd1 = lc3;
        @(negedge clk);
        check("l1_wr_busy", {127'd0, resp1}, 128'd0);
        @(negedge clk);
        check("l1_wr_resp", {127'd0, resp1}, 128'd1);
        wr1 = 1'b0;
        @(negedge clk);
        rd1 = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            check($sformatf("l1_b2b_resp[%0d]", k), {127'd0, resp1},
                  {127'd0, (k % 3) == 2});
            if ((k % 3) == 2) check($sformatf("l1_b2b_rdata[%0d]", k), rdata1, lc3);
        end
        rd1 = 1'b0;

        repeat (3) @(negedge clk);
        check("sb_drained", 128'(sb_q.size()), 128'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
